// File: rtl/sin_wave_rom_if.sv
// Bus between the sample-address counter and the waveform memory.
// The master drives address/data/wren and receives the registered sample q.
interface sin_wave_rom_if;
   logic [9:0]  address;
   logic [13:0] data;
   logic        wren;
   logic [13:0] q;

   modport master (output address, output data, output wren, input q);
   modport slave  (input address, input data, input wren, output q);
endinterface

// File: rtl/sin_wave_rom.sv
// 1024 x 14 waveform memory with a registered read port.
// It is preloaded with CYCLES periods of sine, triangle, square or sawtooth.
module sin_wave_rom #(
   parameter int WAVE   = 0,
   parameter int CYCLES = 1
) (
   input  logic           clock,
   input  logic           reset,
   sin_wave_rom_if.slave  bus
);
   localparam int DEPTH = 1024;

   typedef logic [13:0] mem_t [DEPTH];

   if (WAVE < 0 || WAVE > 3) begin : g_bad_wave
      $error("sin_wave_rom: WAVE must be 0..3");
   end
   if (CYCLES < 1 || CYCLES > 512 || (CYCLES & (CYCLES - 1)) != 0) begin : g_bad_cycles
      $error("sin_wave_rom: CYCLES must be a power of two in 1..512");
   end

   // Sine in fixed point with 2^30 scale. The angle is folded into the first
   // quadrant, and a Taylor series to x^15 is evaluated there.
   function automatic logic [13:0] sine_word(input logic [9:0] p);
      logic [8:0]  r;
      logic [8:0]  qa;
      logic [63:0] x;
      logic [63:0] x2;
      logic [63:0] term;
      logic [63:0] acc;
      logic [63:0] mag;
      r    = p[8:0];
      qa   = r[8] ? 9'(10'd512 - {1'b0, r}) : r;
      x    = (64'(qa) * 64'd3373259426) >> 9;
      x2   = (x * x) >> 30;
      term = x;
      acc  = x;
      for (int k = 1; k <= 7; k++) begin
         term = ((term * x2) >> 30) / 64'((2 * k) * (2 * k + 1));
         acc  = k[0] ? acc - term : acc + term;
      end
      // Rounding the magnitude gives round-half-away-from-zero in both half periods
      mag = (acc * 64'd8191 + 64'd536870912) >> 30;
      return p[9] ? 14'(64'd8192 - mag) : 14'(64'd8192 + mag);
   endfunction

   function automatic mem_t gen_mem();
      mem_t       m;
      logic [9:0] p;
      for (int n = 0; n < DEPTH; n++) begin
         p = 10'(n * CYCLES);
         case (WAVE)
            0:       m[n] = sine_word(p);
            1:       m[n] = p[9] ? {~p[8:0], 5'd0} : {p[8:0], 5'd0};
            2:       m[n] = p[9] ? 14'd0 : 14'h3FFF;
            default: m[n] = {p, 4'd0};
         endcase
      end
      return m;
   endfunction

   mem_t        mem_q = gen_mem();
   logic [13:0] q_q   = '0;
   logic [13:0] q_d;

   // Reading the memory before it is written gives the old word on read-during-write.
   always_comb begin
      q_d = mem_q[bus.address];
   end

   // Reset has no effect on the contents. It only blocks writes.
   always_ff @(posedge clock) begin
      if (bus.wren && !reset) begin
         mem_q[bus.address] <= bus.data;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign bus.q = q_q;
endmodule

// File: tb/tb_sin_wave_rom.sv
// Directed bench for sin_wave_rom. It covers sine, multi-period and other shape preloads,
// read-during-write, async reset, and the address wrap.
module tb_sin_wave_rom;
   logic clock;
   logic reset;
   int   n_tests = 0;
   int   n_fail  = 0;

   sin_wave_rom_if sin1_if ();
   sin_wave_rom_if sin2_if ();
   sin_wave_rom_if sin4_if ();
   sin_wave_rom_if tri_if ();
   sin_wave_rom_if sq_if ();
   sin_wave_rom_if saw_if ();

   sin_wave_rom #(.WAVE(0), .CYCLES(1)) u_sin1 (.clock(clock), .reset(reset), .bus(sin1_if));
   sin_wave_rom #(.WAVE(0), .CYCLES(2)) u_sin2 (.clock(clock), .reset(reset), .bus(sin2_if));
   sin_wave_rom #(.WAVE(0), .CYCLES(4)) u_sin4 (.clock(clock), .reset(reset), .bus(sin4_if));
   sin_wave_rom #(.WAVE(1), .CYCLES(1)) u_tri  (.clock(clock), .reset(reset), .bus(tri_if));
   sin_wave_rom #(.WAVE(2), .CYCLES(1)) u_sq   (.clock(clock), .reset(reset), .bus(sq_if));
   sin_wave_rom #(.WAVE(3), .CYCLES(1)) u_saw  (.clock(clock), .reset(reset), .bus(saw_if));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic set_addr(input logic [9:0] a);
      sin1_if.address = a;
      sin2_if.address = a;
      sin4_if.address = a;
      tri_if.address  = a;
      sq_if.address   = a;
      saw_if.address  = a;
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset = 1'b0;
      set_addr(10'd0);
      sin1_if.data = '0; sin1_if.wren = 1'b0;
      sin2_if.data = '0; sin2_if.wren = 1'b0;
      sin4_if.data = '0; sin4_if.wren = 1'b0;
      tri_if.data  = '0; tri_if.wren  = 1'b0;
      sq_if.data   = '0; sq_if.wren   = 1'b0;
      saw_if.data  = '0; saw_if.wren  = 1'b0;

      #1;
      chk("pwrup_q", 32'(sin1_if.q), 32'd0);
      #1 reset = 1'b1;
      #1;
      chk("rst_q", 32'(sin1_if.q), 32'd0);
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;

      // Continuous sweep: q at each sample reflects the address of the previous edge
      for (int a = 0; a < 1024; a++) begin
         set_addr(10'(a));
         tick();
         chk("sin_range", 32'(sin1_if.q >= 14'd1 && sin1_if.q <= 14'd16383), 32'd1);
         case (a)
            0:    chk("sin_a0",    32'(sin1_if.q), 32'd8192);
            128:  begin
                     chk("sin_a128",  32'(sin1_if.q), 32'd13984);
                     chk("sin2_a128", 32'(sin2_if.q), 32'd16383);
                  end
            64:   chk("sin4_a64",  32'(sin4_if.q), 32'd16383);
            256:  chk("sin_a256",  32'(sin1_if.q), 32'd16383);
            511:  begin
                     chk("tri_a511", 32'(tri_if.q), 32'd16352);
                     chk("sq_a511",  32'(sq_if.q),  32'd16383);
                  end
            512:  begin
                     chk("sin_a512",  32'(sin1_if.q), 32'd8192);
                     chk("sin2_a512", 32'(sin2_if.q), 32'd8192);
                     chk("sin4_a512", 32'(sin4_if.q), 32'd8192);
                     chk("sq_a512",   32'(sq_if.q),   32'd0);
                  end
            768:  chk("sin_a768",  32'(sin1_if.q), 32'd1);
            1022: chk("sin_a1022", 32'(sin1_if.q), 32'd8091);
            1023: begin
                     chk("sin_a1023", 32'(sin1_if.q), 32'd8142);
                     chk("tri_a1023", 32'(tri_if.q),  32'd0);
                     chk("saw_a1023", 32'(saw_if.q),  32'd16368);
                     #6;
                     chk("wrap_hold1023", 32'(sin1_if.q), 32'd8142);
                  end
            default: ;
         endcase
      end

      // Wrap 1023 -> 0
      set_addr(10'd0);
      tick();
      chk("wrap_a0", 32'(sin1_if.q), 32'd8192);
      #6;
      chk("wrap_hold0", 32'(sin1_if.q), 32'd8192);

      // Read-during-write returns the old word, then the new word
      set_addr(10'd5);
      sin1_if.data = 14'h1ABC;
      sin1_if.wren = 1'b1;
      tick();
      chk("rdw_old", 32'(sin1_if.q), 32'd8443);
      sin1_if.wren = 1'b0;
      tick();
      chk("wr_new", 32'(sin1_if.q), 32'h1ABC);

      // Async reset between edges, then a write during reset must be dropped
      set_addr(10'd300);
      tick();
      chk("pre_rst_nz", 32'(sin1_if.q != 14'd0), 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("arst_q", 32'(sin1_if.q), 32'd0);
      set_addr(10'd5);
      sin1_if.data = 14'h0123;
      sin1_if.wren = 1'b1;
      tick();
      chk("rst_hold_q", 32'(sin1_if.q), 32'd0);
      #2 reset = 1'b0;
      sin1_if.wren = 1'b0;
      tick();
      chk("wr_dropped", 32'(sin1_if.q), 32'h1ABC);
      set_addr(10'd256);
      tick();
      chk("post_rst_a256", 32'(sin1_if.q), 32'd16383);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/sin_wave_rom.md
# sin_wave_rom

Single-port 1024 × 14-bit waveform memory with a registered read port. It is preloaded at elaboration with one of four periodic waveforms (sine, triangle, square, sawtooth), repeated a configurable number of times across the address space. It sits between the sample-address counter of the signal generator and the 14-bit DAC/display path. The counter sweeps the address at the DAC clock, and `q` drives the sample value. The `sin_test`, `sin_test1` and `sin_test2` instances are parameterizations of this block.

## Interface
Parameters:
- `WAVE`, default 0: preload shape. 0 = sine, 1 = triangle, 2 = square, 3 = sawtooth. Any other value is an elaboration error.
- `CYCLES`, default 1: number of waveform periods stored in 1024 words. Must be a power of two in 1..512; any other value is an elaboration error.
- Instance settings:
  - `sin_test`: `WAVE`=0, `CYCLES`=1
  - `sin_test1`: `WAVE`=0, `CYCLES`=2
  - `sin_test2`: `WAVE`=0, `CYCLES`=4

Ports:
- `clock` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `address` in 10: word address, 0..1023.
- `data` in 14: write data.
- `wren` in 1: write enable, active high. Tied to 0 for ROM use.
- `q` out 14: registered read data, unsigned offset-binary sample.

## Operation
- Preload index: p = (n × `CYCLES`) mod 1024 for word n.
- Preload contents by shape:
  - sine: mem[n] = 8192 + round(8191 × sin(2π·p/1024)). Range 1..16383. Round half away from zero; ±1 LSB tolerance is allowed only at words where the real value lies within 0.01 of a .5 boundary.
  - triangle: mem[n] = 32·p for p < 512, and 32·(1023 − p) for p ≥ 512.
  - square: mem[n] = 16383 for p < 512, and 0 for p ≥ 512.
  - sawtooth: mem[n] = 16·p.
- Contents are computed at elaboration (constant function or initial loop). No runtime init sequence.
- Read: on every rising edge, q ← mem[address] (the value before any write that occurs on the same edge).
- Write: on a rising edge with `wren`=1 and `reset`=0, mem[address] ← `data`.
- Read-during-write to the same address returns the old word on `q`. The new word is visible from the next read.
- Reset:
  - Asserting `reset` forces `q` to 0 immediately, with no clock needed.
  - `q` holds 0 while `reset` is high.
  - Writes are ignored while `reset` is high.
  - Memory contents are never altered by reset. Preloaded or written data survive reset.
- Address wrap is not handled internally: 10-bit `address` covers exactly 0..1023, and the counter wrap 1023 → 0 reads mem[0] on the next edge.
- No X propagation: `q` is always a defined 14-bit value after reset or after the first clock edge.

## Timing
- Read latency: 1 cycle. The `address` value present at rising edge k appears on `q` after edge k, and stays valid until edge k+1.
- Continuous sweep: with the address incrementing every cycle, `q` is a 1-cycle-delayed sample stream.
- Write takes effect at the edge where `wren`=1. A read of that address at edge k+1 or later returns the new data.
- Reset deassertion: the first capture of mem[address] into `q` happens at the first rising edge after `reset` falls.
- Power-up value of `q` before any edge or reset: 0.

## Test plan
- **Sine preload** (`WAVE`=0, `CYCLES`=1):
  - Reset, then sweep address 0..1023, one address per cycle.
  - `q` one cycle later must read: address 0 → 8192; 256 → 16383; 512 → 8192; 768 → 1; 128 → 13984.
  - All 1024 words must lie within 1..16383.
- **Multi-period preload** (`CYCLES`=2 and 4): address 128 → 16383 for `CYCLES`=2, and address 64 → 16383 for `CYCLES`=4. Address 512 → 8192 in both cases.
- **Other shapes**:
  - triangle, `CYCLES`=1: address 511 → 16352; address 1023 → 0.
  - square: address 511 → 16383; address 512 → 0.
  - sawtooth: address 1023 → 16368.
- **Write and read-during-write**:
  - Write 0x1ABC to address 5 with `wren`=1 while reading address 5: `q` shows the old value 8192 + round(8191·sin(2π·5/1024)) = 8443.
  - The next read of address 5 returns 0x1ABC.
- **Asynchronous reset mid-sweep**:
  - Assert `reset` between clock edges: `q` goes to 0 before the next edge.
  - A write attempted during reset is dropped.
  - After release, address 256 reads 16383 (contents intact).
- **Wrap**: address sequence 1022, 1023, 0 gives `q` = mem[1022], mem[1023], 8192 on consecutive cycles, with no glitch value in between.
